// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: opcode constants seen
// by the main control decoder, the NOP word, the fetch FSM state type and
// the opcode field position inside an instruction word.
package instr_fetch_pkg;

  localparam logic [31:0] NOP_WORD = '0;

  // Opcodes that reach decode; fetch passes them through untouched.
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_39    = 6'd39;
  localparam logic [5:0] OP_40    = 6'd40;
  localparam logic [5:0] OP_41    = 6'd41;
  localparam logic [5:0] OP_42    = 6'd42;
  localparam logic [5:0] OP_54    = 6'd54;

  // Opcode field slice within the instruction word.
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;

  typedef enum logic {
    REQ,
    FULL
  } fetchState_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req   : fetch request, level, from fetch
//   imem_addr  : word-aligned fetch address, from fetch
//   imem_ack   : one-cycle acknowledge, from memory
//   imem_rdata : instruction word, valid with imem_ack, from memory
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_skid.sv
// One-entry skid buffer holding a fetched {instr, pc4} pair while decode is
// stalled.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : capture instrIn/pc4In, mark full
//   unload      : entry consumed, mark empty
//   flush       : drop the entry (redirect)
//   instrOut/pc4Out/full : buffered entry and occupancy
module fetch_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] instrIn,
  input  logic [31:0] pc4In,
  output logic [31:0] instrOut,
  output logic [31:0] pc4Out,
  output logic        full
);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      full     <= 1'b0;
      instrOut <= '0;
      pc4Out   <= '0;
    end else if (load) begin
      full     <= 1'b1;
      instrOut <= instrIn;
      pc4Out   <= pc4In;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Issues word reads over a req/ack bus, advances the PC, and presents the
// fetched instruction, its opcode and PC+4 to decode. A one-entry skid
// buffer absorbs a word that arrives while decode is stalled; redirect
// squashes IF/ID and the skid entry and refetches from the target.
//   clk, rst_n  : clock, synchronous active-low reset
//   imem        : instruction-memory bus (master side)
//   stall       : decode cannot accept; hold a valid IF/ID entry
//   redirect    : taken branch/jump, redirect_pc is the target
//   Instr/Op/PC4/valid : IF/ID register contents
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_if.master       imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic [31:0]         Instr,
  output logic [5:0]          Op,
  output logic [31:0]         PC4,
  output logic                valid
);

  fetchState_t state;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic [31:0] skidInstr;
  logic [31:0] skidPc4;
  logic        skidFull;
  logic        skidLoad;
  logic        skidUnload;

  assign pcNext         = pc + 32'd4;
  assign imem.imem_req  = rst_n && (state == REQ);
  assign imem.imem_addr = pc;
  assign Op             = Instr[OP_MSB:OP_LSB];

  // A word arriving while decode holds a valid entry goes to the skid.
  assign skidLoad   = !redirect && (state == REQ) && imem.imem_ack && valid && stall;
  assign skidUnload = !redirect && (state == FULL) && !stall;

  fetch_skid uSkid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skidLoad),
    .unload   (skidUnload),
    .flush    (redirect),
    .instrIn  (imem.imem_rdata),
    .pc4In    (pcNext),
    .instrOut (skidInstr),
    .pc4Out   (skidPc4),
    .full     (skidFull)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= REQ;
      pc    <= RESET_PC;
      valid <= 1'b0;
      Instr <= NOP_WORD;
      PC4   <= '0;
    end else if (redirect) begin
      // Any same-cycle ack data is dropped by not writing IF/ID here.
      state <= REQ;
      pc    <= alignWord(redirect_pc);
      valid <= 1'b0;
      Instr <= NOP_WORD;
    end else begin
      case (state)
        REQ: begin
          if (imem.imem_ack) begin
            pc <= pcNext;
            if (!valid || !stall) begin
              Instr <= imem.imem_rdata;
              PC4   <= pcNext;
              valid <= 1'b1;
            end else begin
              state <= FULL;
            end
          end else if (!stall) begin
            valid <= 1'b0;
            Instr <= NOP_WORD;
          end
        end
        FULL: begin
          if (!stall && skidFull) begin
            Instr <= skidInstr;
            PC4   <= skidPc4;
            valid <= 1'b1;
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule
